// File: rtl/sc_max7219_rx_if.sv
// Serial load bus of a MAX7219-style display driver (DIN / LOAD-NCS / CLK).
// The controller side drives it; the receiver samples it asynchronously.
interface sc_max7219_rx_if;
    logic SC_MAX7219_RX_DIN_In;
    logic SC_MAX7219_RX_NCS_In;
    logic SC_MAX7219_RX_SCLK_In;

    modport master (
        output SC_MAX7219_RX_DIN_In,
        output SC_MAX7219_RX_NCS_In,
        output SC_MAX7219_RX_SCLK_In
    );

    modport slave (
        input SC_MAX7219_RX_DIN_In,
        input SC_MAX7219_RX_NCS_In,
        input SC_MAX7219_RX_SCLK_In
    );
endinterface

// File: rtl/sc_max7219_rx.sv
// MAX7219 serial-protocol receiver: oversamples the asynchronous serial bus,
// assembles 16-bit frames between NCS fall and rise, and decodes them into the
// MAX7219 register set (digits, decode mode, intensity, scan limit, shutdown,
// display test).
module sc_max7219_rx #(
    parameter int unsigned DATAWIDTH_BUS = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     SC_MAX7219_RX_CLOCK_50,
    input  logic                     SC_MAX7219_RX_RESET_InHigh,
    sc_max7219_rx_if.slave           ser_if,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit0_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit1_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit2_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit3_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit4_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit5_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit6_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_Digit7_Out,
    output logic [3:0]               SC_MAX7219_RX_Intensity_Out,
    output logic [2:0]               SC_MAX7219_RX_ScanLimit_Out,
    output logic [7:0]               SC_MAX7219_RX_DecodeMode_Out,
    output logic                     SC_MAX7219_RX_Shutdown_Out,
    output logic                     SC_MAX7219_RX_DisplayTest_Out,
    output logic                     SC_MAX7219_RX_FrameValid_Out,
    output logic                     SC_MAX7219_RX_FrameError_Out,
    output logic [15:0]              SC_MAX7219_RX_LastFrame_Out
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic                     clk;
    logic                     rst;
    logic [SYNC_STAGES-1:0]   din_sync_q;
    logic [SYNC_STAGES-1:0]   ncs_sync_q;
    logic [SYNC_STAGES-1:0]   sclk_sync_q;
    logic                     ncs_prev_q;
    logic                     sclk_prev_q;
    logic                     din_s, ncs_s, sclk_s;
    logic                     ncs_fall, ncs_rise, sclk_rise;
    logic [1:0]               fill_q;
    logic                     armed_q;
    state_e                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [15:0]              shreg_q, shreg_d;
    logic                     latch, discard;
    logic [DATAWIDTH_BUS-1:0] digit_q [8];
    logic [3:0]               intensity_q;
    logic [2:0]               scan_limit_q;
    logic [7:0]               decode_mode_q;
    logic                     shutdown_q;
    logic                     display_test_q;
    logic                     valid_q;
    logic                     error_q;
    logic [15:0]              last_frame_q;

    assign clk = SC_MAX7219_RX_CLOCK_50;
    assign rst = SC_MAX7219_RX_RESET_InHigh;

    assign din_s  = din_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Synchronizer chains plus one edge-detect flop per control input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync_q  <= '0;
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], ser_if.SC_MAX7219_RX_DIN_In};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ser_if.SC_MAX7219_RX_NCS_In};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_if.SC_MAX7219_RX_SCLK_In};
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    // The NCS chain is preset high, so a pin held low through reset would look
    // like a fresh fall. Only arm frame start once a real high NCS has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            if (fill_q != 2'(SYNC_STAGES)) begin
                fill_q <= fill_q + 2'd1;
            end else if (ncs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM state, shift register and saturating bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: NCS rise takes priority over a coincident SCLK rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        latch   = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall && armed_q) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StIdle;
                    if (cnt_q == 5'd16) begin
                        latch = 1'b1;
                    end else begin
                        discard = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[14:0], din_s};
                    if (cnt_q != 5'd16) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register file: decode the completed word by its address nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            decode_mode_q  <= '0;
            shutdown_q     <= 1'b1;
            display_test_q <= 1'b0;
            valid_q        <= 1'b0;
            error_q        <= 1'b0;
            last_frame_q   <= '0;
        end else begin
            valid_q <= latch;
            error_q <= discard;
            if (latch) begin
                last_frame_q <= shreg_q;
                case (shreg_q[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                        digit_q[3'(shreg_q[11:8] - 4'h1)] <= DATAWIDTH_BUS'(shreg_q[7:0]);
                    4'h9:    decode_mode_q  <= shreg_q[7:0];
                    4'hA:    intensity_q    <= shreg_q[3:0];
                    4'hB:    scan_limit_q   <= shreg_q[2:0];
                    4'hC:    shutdown_q     <= ~shreg_q[0];
                    4'hF:    display_test_q <= shreg_q[0];
                    default: ;
                endcase
            end
        end
    end

    assign SC_MAX7219_RX_Digit0_Out      = digit_q[0];
    assign SC_MAX7219_RX_Digit1_Out      = digit_q[1];
    assign SC_MAX7219_RX_Digit2_Out      = digit_q[2];
    assign SC_MAX7219_RX_Digit3_Out      = digit_q[3];
    assign SC_MAX7219_RX_Digit4_Out      = digit_q[4];
    assign SC_MAX7219_RX_Digit5_Out      = digit_q[5];
    assign SC_MAX7219_RX_Digit6_Out      = digit_q[6];
    assign SC_MAX7219_RX_Digit7_Out      = digit_q[7];
    assign SC_MAX7219_RX_Intensity_Out   = intensity_q;
    assign SC_MAX7219_RX_ScanLimit_Out   = scan_limit_q;
    assign SC_MAX7219_RX_DecodeMode_Out  = decode_mode_q;
    assign SC_MAX7219_RX_Shutdown_Out    = shutdown_q;
    assign SC_MAX7219_RX_DisplayTest_Out = display_test_q;
    assign SC_MAX7219_RX_FrameValid_Out  = valid_q;
    assign SC_MAX7219_RX_FrameError_Out  = error_q;
    assign SC_MAX7219_RX_LastFrame_Out   = last_frame_q;

endmodule
